// File: rtl/mult_share_sched.sv
// Round-robin scheduler that shares one 8x8 signed shift-add multiplier datapath
// between two requesters and returns the product over a valid/ready response.
module mult_share_sched #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned RR_INIT = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_product,
    output logic        rsp_err,
    output logic [7:0]  dp_sw,
    output logic        dp_clra_ldb,
    output logic        dp_run,
    input  logic        dp_done,
    input  logic [15:0] dp_product
);

    localparam int unsigned CW = 8;
    localparam int unsigned OW = 8;
    localparam int unsigned PW = 16;

    typedef enum logic [2:0] {IDLE, LOADB, SETA, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_grant;
    logic          gnt, gnt_id;
    logic [OW-1:0] a_q, b_q, gnt_a, gnt_b;
    logic          id_q;

    logic          req0_ready_n, req1_ready_n, rsp_valid_n, rsp_id_n, rsp_err_n;
    logic [PW-1:0] rsp_product_n;
    logic [OW-1:0] dp_sw_n;
    logic          dp_clra_ldb_n, dp_run_n;

    assign gnt_a = gnt_id ? req1_a : req0_a;
    assign gnt_b = gnt_id ? req1_b : req0_b;

    // State, job context and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'(RR_INIT);
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            dp_sw       <= '0;
            dp_clra_ldb <= 1'b0;
            dp_run      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            if (state == IDLE && gnt) begin
                last_grant <= gnt_id;
                a_q        <= gnt_a;
                b_q        <= gnt_b;
                id_q       <= gnt_id;
            end
            req0_ready  <= req0_ready_n;
            req1_ready  <= req1_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_id      <= rsp_id_n;
            rsp_product <= rsp_product_n;
            rsp_err     <= rsp_err_n;
            dp_sw       <= dp_sw_n;
            dp_clra_ldb <= dp_clra_ldb_n;
            dp_run      <= dp_run_n;
        end
    end

    // Arbitration and sequencing; a tie goes to whoever was not granted last
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt     = 1'b0;
        gnt_id  = last_grant;
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt    = 1'b1;
                    gnt_id = ~last_grant;
                end else if (req0_valid) begin
                    gnt    = 1'b1;
                    gnt_id = 1'b0;
                end else if (req1_valid) begin
                    gnt    = 1'b1;
                    gnt_id = 1'b1;
                end
                if (gnt) begin
                    state_n = LOADB;
                    cnt_n   = '0;
                end
            end
            LOADB: begin
                if (cnt == CW'(1)) state_n = SETA;
                else               cnt_n   = cnt + CW'(1);
            end
            SETA: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                cnt_n = cnt + CW'(1);
                if (dp_done || cnt == CW'(TIMEOUT - 1)) state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    always_comb begin
        req0_ready_n  = 1'b0;
        req1_ready_n  = 1'b0;
        rsp_valid_n   = (state_n == RESP);
        rsp_id_n      = rsp_id;
        rsp_product_n = rsp_product;
        rsp_err_n     = rsp_err;
        dp_sw_n       = '0;
        dp_clra_ldb_n = 1'b0;
        dp_run_n      = 1'b0;
        case (state_n)
            LOADB: begin
                dp_sw_n       = (state == IDLE) ? gnt_b : b_q;
                dp_clra_ldb_n = 1'b1;
            end
            SETA:  dp_sw_n = a_q;
            WAIT: begin
                dp_sw_n  = a_q;
                dp_run_n = 1'b1;
            end
            default: ;
        endcase
        if (state == IDLE && gnt) begin
            req0_ready_n = ~gnt_id;
            req1_ready_n = gnt_id;
        end
        if (state == WAIT && state_n == RESP) begin
            rsp_id_n      = id_q;
            rsp_product_n = dp_done ? dp_product : '0;
            rsp_err_n     = ~dp_done;
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural shift-add datapath model.
module tb_mult_share_sched;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_product;
    logic [7:0]  dp_sw;
    logic        dp_clra_ldb, dp_run;
    logic        dp_done = 1'b0;
    logic [15:0] dp_product = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    mult_share_sched #(.TIMEOUT(32), .RR_INIT(0)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err),
        .dp_sw(dp_sw), .dp_clra_ldb(dp_clra_ldb), .dp_run(dp_run),
        .dp_done(dp_done), .dp_product(dp_product)
    );

    always #5 Clk = ~Clk;

    // Datapath model: loads B while ClearA_LoadB, multiplies 8 cycles after Run, holds until Run drops
    logic [7:0] mb = 8'h00;
    int         dcnt = 0;
    bit         stall = 1'b0;
    always @(posedge Clk) begin
        if (dp_clra_ldb) mb <= dp_sw;
        if (!dp_run) begin
            dcnt    <= 0;
            dp_done <= 1'b0;
        end else if (!dp_done) begin
            if (dcnt >= 7 && !stall) begin
                dp_done    <= 1'b1;
                dp_product <= 16'(int'($signed(dp_sw)) * int'($signed(mb)));
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
                  dp_sw, dp_clra_ldb, dp_run}, 32'h0);
    endtask

    task automatic wait_grant(input bit exp_id, input logic [7:0] exp_b);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (req0_ready || req1_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("grant_seen", 32'(seen), 32'h1);
        chk("grant_id", {req1_ready, req0_ready}, exp_id ? 32'h2 : 32'h1);
        chk("loadb_sw", dp_sw, exp_b);
        chk("loadb_ldb", dp_clra_ldb, 32'h1);
        if (exp_id) req1_valid = 1'b0;
        else        req0_valid = 1'b0;
        @(negedge Clk);
        chk("ready_pulse", {req1_ready, req0_ready}, 32'h0);
    endtask

    task automatic wait_rsp(input bit exp_id, input logic [15:0] exp_p, input bit exp_err,
                            input int exp_wait);
        int runs = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (dp_run) runs++;
            @(negedge Clk);
        end
        chk("rsp_seen", 32'(seen), 32'h1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_product", rsp_product, exp_p);
        chk("rsp_err", rsp_err, exp_err);
        chk("wait_cycles", runs, exp_wait);
        chk("rsp_dp_run", dp_run, 32'h0);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
        chk("rsp_clear", rsp_valid, 32'h0);
        chk("accept_gap", {req1_ready, req0_ready}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        repeat (2) @(negedge Clk);
        chk_idle("reset_outputs");
        Reset = 1'b0;

        // single job on requester 0: 7 * -3
        req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'hFD;
        wait_grant(1'b0, 8'hFD);
        wait_rsp(1'b0, 16'hFFEB, 1'b0, 9);
        accept();

        // contention, two rounds: requester 1 wins each tie, then the held requester 0
        for (int r = 0; r < 2; r++) begin
            req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h05;
            req1_valid = 1'b1; req1_a = 8'hFE; req1_b = 8'hFC;
            wait_grant(1'b1, 8'hFC);
            wait_rsp(1'b1, 16'h0008, 1'b0, 9);
            accept();
            wait_grant(1'b0, 8'h05);
            wait_rsp(1'b0, 16'h000F, 1'b0, 9);
            accept();
        end

        // backpressure with a pending requester 1
        req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h01;
        wait_grant(1'b0, 8'h01);
        wait_rsp(1'b0, 16'hFF80, 1'b0, 9);
        req1_valid = 1'b1; req1_a = 8'h7F; req1_b = 8'h7F;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("bp_rsp", {rsp_valid, rsp_id, rsp_err, rsp_product}, 32'h4FF80);
            chk("bp_ready", {req1_ready, req0_ready, dp_run}, 32'h0);
        end
        accept();
        wait_grant(1'b1, 8'h7F);
        wait_rsp(1'b1, 16'h3F01, 1'b0, 9);
        accept();

        // zero operand
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h55;
        wait_grant(1'b0, 8'h55);
        wait_rsp(1'b0, 16'h0000, 1'b0, 9);
        accept();

        // timeout: datapath never finishes
        stall = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h03;
        wait_grant(1'b1, 8'h03);
        wait_rsp(1'b1, 16'h0000, 1'b1, 32);
        accept();
        stall = 1'b0;

        // reset in the middle of WAIT
        req0_valid = 1'b1; req0_a = 8'h02; req0_b = 8'h02;
        wait_grant(1'b0, 8'h02);
        for (int i = 0; i < 10; i++) begin
            if (dp_run) break;
            @(negedge Clk);
        end
        chk("mid_wait_run", dp_run, 32'h1);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk_idle("reset_mid_wait");
        Reset = 1'b0;
        @(negedge Clk);
        chk_idle("after_reset_idle");

        // fresh job after reset: -128 * -128
        req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h80;
        wait_grant(1'b0, 8'h80);
        wait_rsp(1'b0, 16'h4000, 1'b0, 9);
        accept();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
